// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: write-path arbiter/sequencer for the 2x2 AXI interconnect.
// Define WR_ARB_FIXED_PRIO_EN for fixed M1-over-M0 priority (no round robin).
module axi_wr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int SEL_BIT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              AWVALID_M0,
  input  logic              AWVALID_M1,
  input  logic [ADDR_W-1:0] AWADDR_M0,
  input  logic [ADDR_W-1:0] AWADDR_M1,
  input  logic              AWREADY_S0,
  input  logic              AWREADY_S1,
  input  logic              WVALID_M0,
  input  logic              WVALID_M1,
  input  logic              WLAST_M0,
  input  logic              WLAST_M1,
  input  logic              WREADY_S0,
  input  logic              WREADY_S1,
  input  logic              BVALID_S0,
  input  logic              BVALID_S1,
  input  logic              BREADY_M0,
  input  logic              BREADY_M1,
  output logic [1:0]        gnt,
  output logic [1:0]        slv_sel,
  output logic              aw_en,
  output logic              w_en,
  output logic              b_en,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic g_awvalid;
  logic g_wvalid;
  logic g_wlast;
  logic g_bready;
  logic s_awready;
  logic s_wready;
  logic s_bvalid;

  logic any_req;
  logic pick_m1;
  logic win_sel;
  logic aw_hs;
  logic w_beat;
  logic b_done;

  logic unused_addr;
  assign unused_addr = ^{AWADDR_M0, AWADDR_M1};

  // Only the granted master and selected slave are ever looked at.
  always_comb begin
    g_awvalid = 1'b0;
    g_wvalid  = 1'b0;
    g_wlast   = 1'b0;
    g_bready  = 1'b0;
    unique case (1'b1)
      gnt[0]: begin
        g_awvalid = AWVALID_M0;
        g_wvalid  = WVALID_M0;
        g_wlast   = WLAST_M0;
        g_bready  = BREADY_M0;
      end
      gnt[1]: begin
        g_awvalid = AWVALID_M1;
        g_wvalid  = WVALID_M1;
        g_wlast   = WLAST_M1;
        g_bready  = BREADY_M1;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    unique case (1'b1)
      slv_sel[0]: begin
        s_awready = AWREADY_S0;
        s_wready  = WREADY_S0;
        s_bvalid  = BVALID_S0;
      end
      slv_sel[1]: begin
        s_awready = AWREADY_S1;
        s_wready  = WREADY_S1;
        s_bvalid  = BVALID_S1;
      end
      default: ;
    endcase
  end

  assign any_req = AWVALID_M0 | AWVALID_M1;

`ifdef WR_ARB_FIXED_PRIO_EN
  assign pick_m1 = AWVALID_M1;
`else
  logic last_m1;
  assign pick_m1 = AWVALID_M1 & (~AWVALID_M0 | ~last_m1);
`endif

  assign win_sel = pick_m1 ? AWADDR_M1[SEL_BIT]
                           : AWADDR_M0[SEL_BIT];

  assign aw_hs  = (state == S_ADDR) & g_awvalid & s_awready;
  assign w_beat = (state == S_DATA) & g_wvalid & s_wready;
  assign b_done = (state == S_RESP) & s_bvalid & g_bready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (any_req) state_nxt = S_ADDR;
      S_ADDR: if (aw_hs) state_nxt = S_DATA;
      S_DATA: if (w_beat && g_wlast) state_nxt = S_RESP;
      S_RESP: if (b_done) state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= S_IDLE;
      gnt      <= 2'b00;
      slv_sel  <= 2'b00;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt      <= {pick_m1, ~pick_m1};
            slv_sel  <= {win_sel, ~win_sel};
            beat_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_beat && (beat_cnt != '1))
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
        S_RESP: begin
          if (b_done) begin
            gnt     <= 2'b00;
            slv_sel <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef WR_ARB_FIXED_PRIO_EN
  // Reset to M1 so that M0 takes the first tie.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)
      last_m1 <= 1'b1;
    else if (b_done)
      last_m1 <= gnt[1];
  end
`endif

  assign aw_en = (state == S_ADDR);
  assign w_en  = (state == S_DATA);
  assign b_en  = (state == S_RESP);
  assign busy  = (state != S_IDLE);

endmodule
